// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage : memory-access pipeline stage (between execute and writeback)
//
// Issues loads/stores to the data memory over a req/ack handshake, aligns
// store data onto byte lanes, extracts and sign/zero-extends load data, stalls
// upstream while an access is outstanding and registers the result into the
// writeback stage on the falling clock edge.  MEMRESULT is a combinational
// forward of the result for the decode stage.
//
// Optional build macro: MEM_TIMEOUT_EN
//    defined   -> a CNT_W-bit counter aborts a WAIT that reaches
//                 TIMEOUT_CYCLES without DM_ACK (WBRES=0, WBDES=0, bus error)
//    undefined -> WAIT persists until DM_ACK
//
// Ports
//    clk, reset (async, active-low)
//    CONTROLW_EXE/INTCONTROLW_EXE/ALURES/MEMDATA/MEMPC/MEMHILO/EXEDES/
//    EXEWRITEHILO       : execute-stage pipeline register outputs
//    DM_RDATA, DM_ACK   : data memory response
//    DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA : data memory request
//    MEM_STALL          : freeze upstream stages
//    MEMRESULT          : combinational forwarding result
//    WB*, CONTROLW_MEM, INTCONTROLW_MEM : registered writeback-stage outputs
// ----------------------------------------------------------------------------
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] CONTROLW_EXE,
   input  logic [7:0]  INTCONTROLW_EXE,
   input  logic [31:0] ALURES,
   input  logic [31:0] MEMDATA,
   input  logic [31:0] MEMPC,
   input  logic [31:0] MEMHILO,
   input  logic [6:0]  EXEDES,
   input  logic [1:0]  EXEWRITEHILO,
   input  logic [31:0] DM_RDATA,
   input  logic        DM_ACK,
   output logic        DM_REQ,
   output logic        DM_WE,
   output logic [31:0] DM_ADDR,
   output logic [3:0]  DM_BE,
   output logic [31:0] DM_WDATA,
   output logic        MEM_STALL,
   output logic [31:0] MEMRESULT,
   output logic [31:0] WBRES,
   output logic [31:0] WBHILO,
   output logic [31:0] WBPC,
   output logic [6:0]  WBDES,
   output logic [1:0]  WBWRITEHILO,
   output logic [31:0] CONTROLW_MEM,
   output logic [7:0]  INTCONTROLW_MEM
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t state_reg, state_next;

   // ---------------- instruction decode ----------------
   logic       mem_read, mem_write, memop, unsigned_ld;
   logic [1:0] size;
   logic       size_byte, size_half, size_word;
   logic       misalign, access, bad_op, load_ok;

   assign mem_read    = CONTROLW_EXE[6];
   assign mem_write   = CONTROLW_EXE[7];
   assign size        = CONTROLW_EXE[9:8];
   assign unsigned_ld = CONTROLW_EXE[10];
   assign memop       = mem_read | mem_write;
   assign size_byte   = (size == 2'b00);
   assign size_half   = (size == 2'b01);
   assign size_word   = (size == 2'b10);

   assign misalign = (size_half & ALURES[0])
                   | (size_word & (ALURES[1:0] != 2'b00))
                   | (size == 2'b11);
   assign access   = memop & ~misalign;
   // A misaligned memory op never reaches memory; it is flagged as a bus error.
   assign bad_op   = memop & misalign;
   // A misaligned load has no memory data, so it forwards ALURES like a non-load.
   assign load_ok  = mem_read & ~misalign;

   // ---------------- optional ack timeout ----------------
   logic timeout;
`ifdef MEM_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_reg;

   // Held at zero in IDLE, so the first WAIT cycle always starts from 0.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset)
         cnt_reg <= '0;
      else if (state_reg == S_IDLE)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end

   assign timeout = (state_reg == S_WAIT) && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES != CNT_W);
   assign timeout    = 1'b0;
`endif

   // An ack arriving in the timeout cycle still completes the access normally.
   logic abort;
   assign abort = timeout & ~DM_ACK;

   // ---------------- FSM: state register ----------------
   always_ff @(negedge clk or negedge reset) begin
      if (!reset)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (access && !DM_ACK) state_next = S_WAIT;
         S_WAIT: if (DM_ACK || timeout) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Request/stall are forced low while reset is held so an aborted access
   // disappears immediately.  In WAIT the upstream stages are frozen, so the
   // address/data outputs derived from the EXE inputs stay constant.
   logic dm_req, mem_stall;
   always_comb begin
      dm_req    = 1'b0;
      mem_stall = 1'b0;
      if (reset) begin
         case (state_reg)
            S_IDLE: begin
               dm_req    = access;
               mem_stall = access & ~DM_ACK;
            end
            S_WAIT: begin
               dm_req    = 1'b1;
               mem_stall = ~DM_ACK & ~timeout;
            end
            default: ;
         endcase
      end
   end

   assign DM_REQ    = dm_req;
   assign MEM_STALL = mem_stall;
   assign DM_WE     = dm_req & mem_write;
   assign DM_ADDR   = {ALURES[31:2], 2'b00};

   // ---------------- store path ----------------
   always_comb begin
      DM_BE = 4'b0000;
      if (mem_write) begin
         if (size_byte)      DM_BE = 4'b0001 << ALURES[1:0];
         else if (size_half) DM_BE = ALURES[1] ? 4'b1100 : 4'b0011;
         else                DM_BE = 4'b1111;
      end
   end

   // Byte store: same byte on every lane; half store: halfword on both halves.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign DM_WDATA[gi*8 +: 8] = size_byte ? MEMDATA[7:0]
                                    : size_half ? MEMDATA[(gi%2)*8 +: 8]
                                    :             MEMDATA[gi*8 +: 8];
      end
   endgenerate

   // ---------------- load path ----------------
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_aligned;

   assign ld_byte = DM_RDATA[{ALURES[1:0], 3'b000} +: 8];
   assign ld_half = ALURES[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];

   always_comb begin
      if (size_byte)
         ld_aligned = unsigned_ld ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      else if (size_half)
         ld_aligned = unsigned_ld ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      else
         ld_aligned = DM_RDATA;
   end

   assign MEMRESULT = load_ok ? ld_aligned : ALURES;

   // ---------------- writeback registers ----------------
   logic [31:0] wbres_reg, wbhilo_reg, wbpc_reg, controlw_reg;
   logic [6:0]  wbdes_reg;
   logic [1:0]  wbwritehilo_reg;
   logic [7:0]  intcontrolw_reg;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         wbres_reg       <= '0;
         wbhilo_reg      <= '0;
         wbpc_reg        <= '0;
         wbdes_reg       <= '0;
         wbwritehilo_reg <= '0;
         controlw_reg    <= '0;
         intcontrolw_reg <= '0;
      end else if (mem_stall) begin
         // Bubble: kill every write/control field, keep data fields.
         wbdes_reg       <= '0;
         wbwritehilo_reg <= '0;
         controlw_reg    <= '0;
         intcontrolw_reg <= '0;
      end else begin
         wbres_reg       <= abort ? 32'd0 : MEMRESULT;
         wbhilo_reg      <= MEMHILO;
         wbpc_reg        <= MEMPC;
         wbdes_reg       <= (bad_op | abort) ? 7'd0 : EXEDES;
         wbwritehilo_reg <= (bad_op | abort) ? 2'd0 : EXEWRITEHILO;
         controlw_reg    <= CONTROLW_EXE;
         intcontrolw_reg <= {INTCONTROLW_EXE[7:4],
                             INTCONTROLW_EXE[3] | bad_op | abort,
                             INTCONTROLW_EXE[2:0]};
      end
   end

   assign WBRES           = wbres_reg;
   assign WBHILO          = wbhilo_reg;
   assign WBPC            = wbpc_reg;
   assign WBDES           = wbdes_reg;
   assign WBWRITEHILO     = wbwritehilo_reg;
   assign CONTROLW_MEM    = controlw_reg;
   assign INTCONTROLW_MEM = intcontrolw_reg;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage : directed self-checking bench for mem_stage.
// Inputs change 1 time unit after the falling (active) edge; combinational
// outputs are sampled after the rising edge, registered outputs 1 time unit
// after the falling edge.
// ----------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] CONTROLW_EXE;
   logic [7:0]  INTCONTROLW_EXE;
   logic [31:0] ALURES, MEMDATA, MEMPC, MEMHILO;
   logic [6:0]  EXEDES;
   logic [1:0]  EXEWRITEHILO;
   logic [31:0] DM_RDATA;
   logic        DM_ACK;
   logic        DM_REQ, DM_WE, MEM_STALL;
   logic [31:0] DM_ADDR, DM_WDATA, MEMRESULT, WBRES, WBHILO, WBPC, CONTROLW_MEM;
   logic [3:0]  DM_BE;
   logic [6:0]  WBDES;
   logic [1:0]  WBWRITEHILO;
   logic [7:0]  INTCONTROLW_MEM;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .reset(reset),
      .CONTROLW_EXE(CONTROLW_EXE), .INTCONTROLW_EXE(INTCONTROLW_EXE),
      .ALURES(ALURES), .MEMDATA(MEMDATA), .MEMPC(MEMPC), .MEMHILO(MEMHILO),
      .EXEDES(EXEDES), .EXEWRITEHILO(EXEWRITEHILO),
      .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK),
      .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_BE(DM_BE),
      .DM_WDATA(DM_WDATA), .MEM_STALL(MEM_STALL), .MEMRESULT(MEMRESULT),
      .WBRES(WBRES), .WBHILO(WBHILO), .WBPC(WBPC), .WBDES(WBDES),
      .WBWRITEHILO(WBWRITEHILO), .CONTROLW_MEM(CONTROLW_MEM),
      .INTCONTROLW_MEM(INTCONTROLW_MEM)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ctrl, input logic [31:0] alu,
                        input logic [31:0] mdata, input logic [6:0] des,
                        input logic [7:0] intc, input logic [31:0] rdata,
                        input logic ack, input logic [31:0] pc,
                        input logic [31:0] hilo, input logic [1:0] whl);
      CONTROLW_EXE    = ctrl;
      ALURES          = alu;
      MEMDATA         = mdata;
      EXEDES          = des;
      INTCONTROLW_EXE = intc;
      DM_RDATA        = rdata;
      DM_ACK          = ack;
      MEMPC           = pc;
      MEMHILO         = hilo;
      EXEWRITEHILO    = whl;
   endtask

   task automatic to_mid;   // just after rising edge: combinational checks
      @(posedge clk); #1;
   endtask

   task automatic to_wb;    // just after falling edge: registered checks
      @(negedge clk); #1;
   endtask

   initial begin
      // ---------------- reset state (request pending on inputs) ----------------
      reset = 1'b0;
      drive(32'h40, 32'h1000, 32'h0, 7'd1, 8'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);
      #3;
      check("rst_req",   DM_REQ,    0);
      check("rst_stall", MEM_STALL, 0);
      check("rst_wbres", WBRES,     0);
      check("rst_wbdes", WBDES,     0);
      check("rst_ctrl",  CONTROLW_MEM, 0);
      check("rst_intc",  INTCONTROLW_MEM, 0);
      $display("txn reset          req=%0b stall=%0b wbres=%08h", DM_REQ, MEM_STALL, WBRES);
      to_wb();
      reset = 1'b1;

      // ---------------- LB 0x1003, ack same cycle ----------------
      drive(32'h40, 32'h1003, 32'h0, 7'd7, 8'h00, 32'h80FF0000, 1'b1, 32'h100, 32'hA5A5A5A5, 2'b10);
      to_mid();
      check("lb_req",   DM_REQ,    1);
      check("lb_we",    DM_WE,     0);
      check("lb_be",    DM_BE,     0);
      check("lb_addr",  DM_ADDR,   32'h1000);
      check("lb_stall", MEM_STALL, 0);
      check("lb_fwd",   MEMRESULT, 32'hFFFFFF80);
      to_wb();
      check("lb_wbres", WBRES,       32'hFFFFFF80);
      check("lb_wbdes", WBDES,       7);
      check("lb_wbpc",  WBPC,        32'h100);
      check("lb_hilo",  WBHILO,      32'hA5A5A5A5);
      check("lb_whl",   WBWRITEHILO, 2);
      check("lb_ctrl",  CONTROLW_MEM, 32'h40);
      $display("txn LB  0x1003     wbres=%08h wbdes=%0d", WBRES, WBDES);

      // ---------------- LBU 0x1003 ----------------
      drive(32'h440, 32'h1003, 32'h0, 7'd8, 8'h00, 32'h80FF0000, 1'b1, 32'h104, 32'h0, 2'b00);
      to_mid();
      check("lbu_fwd", MEMRESULT, 32'h00000080);
      to_wb();
      check("lbu_wbres", WBRES, 32'h00000080);
      $display("txn LBU 0x1003     wbres=%08h", WBRES);

      // ---------------- LH 0x0002 signed ----------------
      drive(32'h140, 32'h0002, 32'h0, 7'd2, 8'h00, 32'h80011234, 1'b1, 32'h108, 32'h0, 2'b00);
      to_mid();
      check("lh_fwd", MEMRESULT, 32'hFFFF8001);
      to_wb();
      check("lh_wbres", WBRES, 32'hFFFF8001);
      $display("txn LH  0x0002     wbres=%08h", WBRES);

      // ---------------- SH 0x2002, ack after 3 stall cycles ----------------
      drive(32'h180, 32'h2002, 32'h0000BEEF, 7'd9, 8'h05, 32'h0, 1'b0, 32'h10C, 32'h0, 2'b01);
      for (int i = 0; i < 3; i++) begin
         to_mid();
         check("sh_stall", MEM_STALL, 1);
         check("sh_req",   DM_REQ,    1);
         check("sh_we",    DM_WE,     1);
         check("sh_be",    DM_BE,     4'b1100);
         check("sh_wdata", DM_WDATA,  32'hBEEFBEEF);
         check("sh_addr",  DM_ADDR,   32'h2000);
         to_wb();
         check("sh_bub_des",  WBDES,           0);
         check("sh_bub_ctrl", CONTROLW_MEM,    0);
         check("sh_bub_intc", INTCONTROLW_MEM, 0);
         check("sh_bub_res",  WBRES,           32'hFFFF8001);
         $display("txn SH  stall %0d    wbdes=%0d wbres=%08h", i, WBDES, WBRES);
         if (i == 2) DM_ACK = 1'b1;
      end
      to_mid();
      check("sh_ack_stall", MEM_STALL, 0);
      check("sh_ack_req",   DM_REQ,    1);
      check("sh_ack_wdata", DM_WDATA,  32'hBEEFBEEF);
      to_wb();
      check("sh_wbres", WBRES,           32'h2002);
      check("sh_wbdes", WBDES,           9);
      check("sh_ctrl",  CONTROLW_MEM,    32'h180);
      check("sh_intc",  INTCONTROLW_MEM, 32'h05);
      check("sh_whl",   WBWRITEHILO,     1);
      $display("txn SH  0x2002 ack wbres=%08h wbdes=%0d", WBRES, WBDES);

      // ---------------- LW 0x3001 misaligned ----------------
      drive(32'h240, 32'h3001, 32'h0, 7'd4, 8'h00, 32'hDEADBEEF, 1'b0, 32'h110, 32'h0, 2'b11);
      to_mid();
      check("lw_mis_req",   DM_REQ,    0);
      check("lw_mis_stall", MEM_STALL, 0);
      to_wb();
      check("lw_mis_intc", INTCONTROLW_MEM, 32'h08);
      check("lw_mis_des",  WBDES,           0);
      check("lw_mis_whl",  WBWRITEHILO,     0);
      $display("txn LW  0x3001 mis intc=%02h wbdes=%0d", INTCONTROLW_MEM, WBDES);

      // ---------------- non-memop pass-through ----------------
      drive(32'h0, 32'h12345678, 32'h0, 7'd5, 8'h00, 32'h0, 1'b0, 32'h114, 32'hCAFEF00D, 2'b01);
      to_mid();
      check("alu_fwd", MEMRESULT, 32'h12345678);
      check("alu_req", DM_REQ,    0);
      to_wb();
      check("alu_wbres", WBRES,       32'h12345678);
      check("alu_wbdes", WBDES,       5);
      check("alu_hilo",  WBHILO,      32'hCAFEF00D);
      check("alu_whl",   WBWRITEHILO, 1);
      $display("txn ALU            wbres=%08h wbdes=%0d", WBRES, WBDES);

      // ---------------- stray ack in IDLE is ignored ----------------
      drive(32'h0, 32'h12345678, 32'h0, 7'd6, 8'h00, 32'h0, 1'b1, 32'h118, 32'h0, 2'b00);
      to_mid();
      check("stray_stall", MEM_STALL, 0);
      check("stray_req",   DM_REQ,    0);
      to_wb();
      check("stray_wbdes", WBDES, 6);
      $display("txn ALU stray ack  wbdes=%0d", WBDES);

      // ---------------- reset asserted during WAIT ----------------
      drive(32'h280, 32'h4000, 32'h11223344, 7'd10, 8'h00, 32'h0, 1'b0, 32'h500, 32'h99, 2'b00);
      to_mid();
      check("sw_stall", MEM_STALL, 1);
      check("sw_be",    DM_BE,     4'b1111);
      check("sw_wdata", DM_WDATA,  32'h11223344);
      to_wb();
      to_mid();
      check("sw_wait_req",   DM_REQ,    1);
      check("sw_wait_stall", MEM_STALL, 1);
      reset = 1'b0;
      #1;
      check("rw_req",   DM_REQ,    0);
      check("rw_stall", MEM_STALL, 0);
      check("rw_wbres", WBRES,     0);
      check("rw_wbpc",  WBPC,      0);
      check("rw_hilo",  WBHILO,    0);
      $display("txn reset in WAIT  req=%0b stall=%0b wbres=%08h", DM_REQ, MEM_STALL, WBRES);
      to_wb();
      reset = 1'b1;
      // Late ack with a non-memop: a stale WAIT state would still request.
      drive(32'h0, 32'h77, 32'h0, 7'd3, 8'h00, 32'h0, 1'b1, 32'h504, 32'h0, 2'b00);
      to_mid();
      check("late_req",   DM_REQ,    0);
      check("late_stall", MEM_STALL, 0);
      to_wb();
      check("late_wbdes", WBDES, 3);
      check("late_wbres", WBRES, 32'h77);
      $display("txn late ack       wbres=%08h wbdes=%0d", WBRES, WBDES);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
